fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   This block reads bytes from a 10-entry byte FIFO and sends each byte out
//   as an 8N1 UART frame (one start bit, eight data bits LSB first, one stop
//   bit). The FIFO exposes only its pointers. When wrptr==rdptr the FIFO could
//   be either empty or full, so this block keeps its own occupancy count by
//   watching the write strobe and its own read strobe.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous, active-high reset (assert with the FIFO reset)
//   fifo_wr    copy of the FIFO write strobe; only monitored
//   fifo_dout  registered FIFO read data; sampled only in LOAD
//   rd         FIFO read strobe; registered and one cycle wide
//   txd        serial output; idle high; driven directly from a flop
//   busy       high from the rd issue until the end of the stop bit
//   count      tracked FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DEPTH        = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_wr,
    input  logic [7:0]       fifo_dout,
    output logic             rd,
    output logic             txd,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;

    logic       inc, dec, baud_last;
    logic [2:0] bit_nxt;

    // Occupancy tracking. A write while full is dropped by the FIFO, so it
    // is not counted. rd_q is set only from IDLE with count_q != 0, so the
    // decrement can never go below zero.
    always_comb begin
        inc     = fifo_wr && (count_q < CNT_MAX);
        dec     = rd_q;
        count_d = count_q;
        if (inc && !dec) begin
            count_d = count_q + 1'b1;
        end else if (!inc && dec) begin
            count_d = count_q - 1'b1;
        end
    end

    // Frame sequencer
    always_comb begin
        state_d   = state_q;
        rd_d      = 1'b0;
        txd_d     = txd_q;
        busy_d    = busy_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        baud_last = (baud_q == BAUD_LAST);
        bit_nxt   = bit_q + 3'd1;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            // rd is high during this cycle. The FIFO presents the byte on
            // fifo_dout at the end of this cycle.
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = fifo_dout;
                txd_d   = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = shreg_q[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            count_q <= '0;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    assign rd    = rd_q;
    assign txd   = txd_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. A behavioural
//   10-entry FIFO drives fifo_dout one edge after rd. Each scenario task
//   drives its stimulus and compares the outputs against values worked out
//   by hand.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_wr = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       rd, txd, busy;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    fifo_uart_tx #(.DEPTH(10), .CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .fifo_wr(fifo_wr), .fifo_dout(fifo_dout),
        .rd(rd), .txd(txd), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data; a write while full is dropped
    logic [7:0] fq[$];
    bit         fq_full;
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_dout <= 8'h00;
        end else begin
            fq_full = (fq.size() >= 10);
            if (rd === 1'b1 && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_wr && !fq_full) fq.push_back(wr_data);
        end
    end

    // Cycle stamps and invariant observations, sampled on the falling edge
    int cyc = 0;
    int rd_rises[$];
    int rd_double = 0, rd_empty = 0, max_count = 0;
    bit rd_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rd === 1'b1 && !rd_prev) rd_rises.push_back(cyc);
        if (rd === 1'b1 && rd_prev) rd_double++;
        if (rd === 1'b1 && count === 4'd0) rd_empty++;
        if (!$isunknown(count) && int'(count) > max_count) max_count = int'(count);
        rd_prev = (rd === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        fifo_wr = 1'b1;
        wr_data = d;
        tick();
        fifo_wr = 1'b0;
    endtask

    // Capture one serial frame. The task waits (bounded) for txd low. It then
    // samples every cycle of all ten bit periods, requires each bit to be
    // stable for CPB cycles, and requires start=0 and stop=1.
    task automatic rx_frame(output logic [7:0] data, output bit ok, output bit to,
                            output int cnt0, output int waited);
        logic v;
        ok = 1'b1; to = 1'b0; data = 8'h00; cnt0 = -1; waited = 0;
        while (txd !== 1'b0 && waited < 300) begin
            tick();
            waited++;
        end
        if (txd !== 1'b0) begin
            to = 1'b1;
            ok = 1'b0;
            return;
        end
        cnt0 = int'(count);
        for (int b = 0; b < 10; b++) begin
            v = txd;
            for (int c = 0; c < CPB; c++) begin
                if (txd !== v) ok = 1'b0;
                tick();
            end
            if (b == 0 && v !== 1'b0) ok = 1'b0;
            if (b == 9 && v !== 1'b1) ok = 1'b0;
            if (b >= 1 && b <= 8) data[b-1] = v;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rd, txd, busy, count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_vals: rd/txd/busy/count got %b/%b/%b/%0d want 0/1/0/0", rd, txd, busy, count);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({rd, txd, busy, count} !== {1'b0, 1'b1, 1'b0, 4'd0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_single();
        logic [7:0] d; bit ok, to; int c0, w;
        rd_rises.delete();
        wr_byte(8'hA5);
        checks++;
        if (count !== 4'd1 || rd !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt1: count/rd got %0d/%b want 1/0", count, rd);
        end
        tick();
        checks++;
        if (rd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rd: rd/busy got %b/%b want 1/1", rd, busy);
        end
        tick();
        checks++;
        if (rd !== 1'b0 || txd !== 1'b1 || count !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_fetch: rd/txd/count/busy got %b/%b/%0d/%b want 0/1/0/1", rd, txd, count, busy);
        end
        rx_frame(d, ok, to, c0, w);
        checks++;
        if (to || !ok || d !== 8'hA5) begin
            errors++;
            $display("FAIL single_frame: data %h ok %0d timeout %0d want a5 1 0", d, ok, to);
        end
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL single_latency: txd fell after %0d more cycles want 1", w);
        end
        checks++;
        if (busy !== 1'b0 || count !== 4'd0 || txd !== 1'b1 || rd_rises.size() != 1) begin
            errors++;
            $display("FAIL single_end: busy/count/txd/rds got %b/%0d/%b/%0d want 0/0/1/1", busy, count, txd, rd_rises.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; bit ok, to; int c0, w;
        logic [7:0] exp_d[3] = '{8'h00, 8'hFF, 8'h3C};
        int exp_c[3] = '{2, 1, 0};
        rd_rises.delete();
        wr_byte(8'h00);
        wr_byte(8'hFF);
        wr_byte(8'h3C);
        for (int k = 0; k < 3; k++) begin
            rx_frame(d, ok, to, c0, w);
            checks++;
            if (to || !ok || d !== exp_d[k] || c0 != exp_c[k]) begin
                errors++;
                $display("FAIL b2b_frame%0d: data %h ok %0d cnt %0d want %h 1 %0d", k, d, ok, c0, exp_d[k], exp_c[k]);
            end
        end
        checks++;
        if (rd_rises.size() != 3) begin
            errors++;
            $display("FAIL b2b_rd_count: got %0d want 3", rd_rises.size());
        end else if (rd_rises[1] - rd_rises[0] != 43 || rd_rises[2] - rd_rises[1] != 43) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d want 43,43", rd_rises[1] - rd_rises[0], rd_rises[2] - rd_rises[1]);
        end
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: count/busy got %0d/%b want 0/0", count, busy);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d; bit ok, to; int c0, w;
        rd_rises.delete();
        max_count = 0;
        fork
            rx_frame(d, ok, to, c0, w);
            begin
                wr_byte(8'h55);
                repeat (6) tick();
                for (int i = 0; i < 12; i++) wr_byte(8'(8'h10 + i));
            end
        join
        checks++;
        if (to || !ok || d !== 8'h55) begin
            errors++;
            $display("FAIL sat_first: data %h ok %0d want 55 1", d, ok);
        end
        checks++;
        if (count !== 4'd10 || max_count != 10) begin
            errors++;
            $display("FAIL sat_full: count %0d max %0d want 10 10", count, max_count);
        end
        for (int k = 0; k < 10; k++) begin
            rx_frame(d, ok, to, c0, w);
            checks++;
            if (to || !ok || d !== 8'(8'h10 + k)) begin
                errors++;
                $display("FAIL sat_frame%0d: data %h ok %0d want %h 1", k, d, ok, 8'(8'h10 + k));
            end
        end
        repeat (5) tick();
        checks++;
        if (count !== 4'd0 || rd_rises.size() != 11 || max_count != 10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_end: count %0d rds %0d max %0d busy %b want 0 11 10 0", count, rd_rises.size(), max_count, busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d; bit ok, to; int c0, w;
        rd_rises.delete();
        wr_byte(8'h81);
        tick();
        checks++;
        if (rd !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL simul_pre: rd/count got %b/%0d want 1/1", rd, count);
        end
        wr_byte(8'h7E);
        checks++;
        if (count !== 4'd1 || rd !== 1'b0) begin
            errors++;
            $display("FAIL simul_cnt: count/rd got %0d/%b want 1/0", count, rd);
        end
        rx_frame(d, ok, to, c0, w);
        checks++;
        if (to || !ok || d !== 8'h81) begin
            errors++;
            $display("FAIL simul_f1: data %h ok %0d want 81 1", d, ok);
        end
        rx_frame(d, ok, to, c0, w);
        checks++;
        if (to || !ok || d !== 8'h7E || count !== 4'd0 || rd_rises.size() != 2) begin
            errors++;
            $display("FAIL simul_f2: data %h ok %0d count %0d rds %0d want 7e 1 0 2", d, ok, count, rd_rises.size());
        end
    endtask

    task automatic test_midreset();
        logic [7:0] d; bit ok, to; int c0, w, n, bad;
        wr_byte(8'hC3);
        wr_byte(8'h0F);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL mid_start: txd never fell, got %b want 0", txd);
        end
        repeat (17) tick();  // now inside data bit 3 (bit 3 of 0xC3 is 0)
        checks++;
        if (txd !== 1'b0 || count !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: txd/count/busy got %b/%0d/%b want 0/1/1", txd, count, busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({rd, txd, busy, count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset: rd/txd/busy/count got %b/%b/%b/%0d want 0/1/0/0", rd, txd, busy, count);
        end
        rst = 1'b0;
        rd_rises.delete();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || rd_rises.size() != 0) begin
            errors++;
            $display("FAIL mid_quiet: bad %0d rds %0d want 0 0", bad, rd_rises.size());
        end
        wr_byte(8'h5A);
        rx_frame(d, ok, to, c0, w);
        checks++;
        if (to || !ok || d !== 8'h5A || rd_rises.size() != 1) begin
            errors++;
            $display("FAIL mid_resume: data %h ok %0d rds %0d want 5a 1 1", d, ok, rd_rises.size());
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (rd_double != 0 || rd_empty != 0) begin
            errors++;
            $display("FAIL invariants: rd_double %0d rd_empty %0d want 0 0", rd_double, rd_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_simultaneous();
        test_midreset();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
